// File: rtl/pixel_array_readout.sv
// pixel_array_readout: selects pixel rows in turn, captures each settled column bus
// into a row buffer and streams the buffered pixels over a valid/ready interface.
`default_nettype none

module pixel_array_readout #(
    parameter int ARRAY_ROWS = 2,
    parameter int ARRAY_COLS = 2,
    parameter int DATA_WIDTH = 8,
    parameter int BUS_SETTLE = 2
) (
    input  logic                             readout_clock,
    input  logic                             readout_reset,
    input  logic                             start,
    output logic                             busy,
    output logic                             frame_done,
    output logic [ARRAY_ROWS-1:0]            row_select,
    input  logic [ARRAY_COLS*DATA_WIDTH-1:0] column_data,
    output logic [DATA_WIDTH-1:0]            pixel_data,
    output logic [$clog2(ARRAY_ROWS):0]      pixel_row,
    output logic [$clog2(ARRAY_COLS):0]      pixel_col,
    output logic                             pixel_valid,
    input  logic                             pixel_ready
);

    localparam int ROW_W = $clog2(ARRAY_ROWS) + 1;
    localparam int COL_W = $clog2(ARRAY_COLS) + 1;
    localparam int SET_W = $clog2(BUS_SETTLE + 1) + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SELECT = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    logic [1:0]                      state;
    logic [1:0]                      state_next;
    logic [ROW_W-1:0]                row;
    logic [COL_W-1:0]                col;
    logic [SET_W-1:0]                settle;
    logic [ARRAY_COLS*DATA_WIDTH-1:0] row_buf;
    logic                            settle_done;
    logic                            last_col;
    logic                            last_row;
    logic                            xfer_last;

    assign settle_done = (settle == SET_W'(BUS_SETTLE));
    assign last_col    = (col == COL_W'(ARRAY_COLS - 1));
    assign last_row    = (row == ROW_W'(ARRAY_ROWS - 1));
    assign xfer_last   = (state == ST_DRAIN) && pixel_ready && last_col;

    always_ff @(posedge readout_clock) begin
        if (!readout_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_SELECT;
            ST_SELECT: if (settle_done) state_next = ST_DRAIN;
            ST_DRAIN:  if (xfer_last) state_next = last_row ? ST_IDLE : ST_SELECT;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Row/column counters, settle timer and row buffer advance with the FSM.
    always_ff @(posedge readout_clock) begin
        if (!readout_reset) begin
            row        <= '0;
            col        <= '0;
            settle     <= '0;
            row_buf    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    row    <= '0;
                    col    <= '0;
                    settle <= '0;
                end
                ST_SELECT: begin
                    if (settle_done) begin
                        row_buf <= column_data;
                        col     <= '0;
                        settle  <= '0;
                    end else begin
                        settle <= settle + SET_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (pixel_ready) begin
                        if (!last_col) begin
                            col <= col + COL_W'(1);
                        end else begin
                            col    <= '0;
                            settle <= '0;
                            if (last_row) begin
                                row        <= '0;
                                frame_done <= 1'b1;
                            end else begin
                                row <= row + ROW_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    row    <= '0;
                    col    <= '0;
                    settle <= '0;
                end
            endcase
        end
    end

    // Pixel outputs are forced to zero outside DRAIN so idle/reset shows all zeros.
    always_comb begin
        busy        = (state != ST_IDLE);
        row_select  = '0;
        pixel_valid = 1'b0;
        pixel_data  = '0;
        pixel_row   = '0;
        pixel_col   = '0;
        if (state == ST_SELECT) begin
            for (int r = 0; r < ARRAY_ROWS; r++) begin
                if (row == ROW_W'(r)) row_select[r] = 1'b1;
            end
        end
        if (state == ST_DRAIN) begin
            pixel_valid = 1'b1;
            pixel_row   = row;
            pixel_col   = col;
            for (int c = 0; c < ARRAY_COLS; c++) begin
                if (col == COL_W'(c)) pixel_data = row_buf[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pixel_array_readout.sv
// tb_pixel_array_readout: directed checks of the 2x2 frame readout sequencer.
`default_nettype none

module tb_pixel_array_readout;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [1:0]  row_select;
    logic [15:0] column_data;
    logic [7:0]  pixel_data;
    logic [1:0]  pixel_row;
    logic [1:0]  pixel_col;
    logic        pixel_valid;
    logic        pixel_ready = 1'b1;
    logic        bus_ovr = 1'b0;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [11:0] xfers[$];
    logic [16:0] frame_exp [12];

    always #5 clk = ~clk;

    // Pixel array model: each selected row drives its own column codes.
    always_comb begin
        if (bus_ovr)                 column_data = 16'hFFFF;
        else if (row_select == 2'b01) column_data = 16'h2211;
        else if (row_select == 2'b10) column_data = 16'h4433;
        else                          column_data = 16'hFFFF;
    end

    pixel_array_readout #(
        .ARRAY_ROWS(2), .ARRAY_COLS(2), .DATA_WIDTH(8), .BUS_SETTLE(2)
    ) dut (
        .readout_clock(clk),
        .readout_reset(rst_n),
        .start(start),
        .busy(busy),
        .frame_done(frame_done),
        .row_select(row_select),
        .column_data(column_data),
        .pixel_data(pixel_data),
        .pixel_row(pixel_row),
        .pixel_col(pixel_col),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        if (pixel_valid && pixel_ready) xfers.push_back({pixel_row, pixel_col, pixel_data});
        @(posedge clk);
        #1;
        if (frame_done) done_cnt++;
    endtask

    task automatic run_to_idle(input string tag);
        int n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_pixel(input string tag, input logic [1:0] r, input logic [1:0] c);
        int n = 0;
        while (!(pixel_valid && pixel_row == r && pixel_col == c) && n < 40) begin
            step();
            n++;
        end
        check({tag, "_reach"}, {31'd0, pixel_valid}, 32'd1);
    endtask

    task automatic check_stream(input string tag);
        logic [11:0] exp [4];
        exp[0] = {2'd0, 2'd0, 8'h11};
        exp[1] = {2'd0, 2'd1, 8'h22};
        exp[2] = {2'd1, 2'd0, 8'h33};
        exp[3] = {2'd1, 2'd1, 8'h44};
        check({tag, "_count"}, xfers.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < xfers.size()) check($sformatf("%s_px%0d", tag, i), {20'd0, xfers[i]}, {20'd0, exp[i]});
        end
    endtask

    initial begin
        // {row_select, valid, row, col, data, frame_done, busy} after each edge of a full frame
        frame_exp[0]  = {2'b01, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1};
        frame_exp[1]  = {2'b01, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1};
        frame_exp[2]  = {2'b01, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1};
        frame_exp[3]  = {2'b00, 1'b1, 2'd0, 2'd0, 8'h11, 1'b0, 1'b1};
        frame_exp[4]  = {2'b00, 1'b1, 2'd0, 2'd1, 8'h22, 1'b0, 1'b1};
        frame_exp[5]  = {2'b10, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1};
        frame_exp[6]  = {2'b10, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1};
        frame_exp[7]  = {2'b10, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1};
        frame_exp[8]  = {2'b00, 1'b1, 2'd1, 2'd0, 8'h33, 1'b0, 1'b1};
        frame_exp[9]  = {2'b00, 1'b1, 2'd1, 2'd1, 8'h44, 1'b0, 1'b1};
        frame_exp[10] = {2'b00, 1'b0, 2'd0, 2'd0, 8'h00, 1'b1, 1'b0};
        frame_exp[11] = {2'b00, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0};

        // Reset held with START asserted, then released with START low
        rst_n = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("rst_out%0d", i),
                  {16'd0, row_select, pixel_valid, pixel_row, pixel_col, pixel_data, frame_done, busy}, 32'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("post_rst%0d", i),
                  {16'd0, row_select, pixel_valid, pixel_row, pixel_col, pixel_data, frame_done, busy}, 32'd0);
        end

        // Full frame, cycle by cycle
        pixel_ready = 1'b1;
        start = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            start = 1'b0;
            check($sformatf("frame_cyc%0d", i),
                  {15'd0, row_select, pixel_valid, pixel_row, pixel_col, pixel_data, frame_done, busy},
                  {15'd0, frame_exp[i]});
        end
        check("frame_done_cnt", done_cnt, 32'd1);

        // Backpressure on (0,1)
        xfers.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_pixel("bp", 2'd0, 2'd1);
        pixel_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("bp_hold%0d", i), {19'd0, pixel_valid, pixel_row, pixel_col, pixel_data},
                  {19'd0, 1'b1, 2'd0, 2'd1, 8'h22});
        end
        pixel_ready = 1'b1;
        run_to_idle("bp");
        check_stream("bp");

        // Capture isolation: bus goes to FF right after the capture edge
        start = 1'b1;
        step();
        start = 1'b0;
        wait_pixel("iso", 2'd0, 2'd0);
        bus_ovr = 1'b1;
        check("iso_px0", {24'd0, pixel_data}, 32'h11);
        step();
        check("iso_px1", {24'd0, pixel_data}, 32'h22);
        bus_ovr = 1'b0;
        run_to_idle("iso");

        // START mid-frame is ignored
        xfers.delete();
        done_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_pixel("mid", 2'd0, 2'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        run_to_idle("mid");
        check_stream("mid");
        check("mid_done_cnt", done_cnt, 32'd1);
        step();
        step();
        check("mid_no_queue", {30'd0, busy, row_select != 2'b00}, 32'd0);

        // START in the FRAME_DONE cycle begins a new frame
        start = 1'b1;
        step();
        start = 1'b0;
        begin
            int n = 0;
            while (!frame_done && n < 40) begin
                step();
                n++;
            end
        end
        check("fd_seen", {31'd0, frame_done}, 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("fd_restart", {30'd0, row_select}, 32'h1);
        check("fd_restart_busy", {31'd0, busy}, 32'd1);
        run_to_idle("fd");

        // Reset in DRAIN at (1,0)
        start = 1'b1;
        step();
        start = 1'b0;
        wait_pixel("rmid", 2'd1, 2'd0);
        pixel_ready = 1'b0;
        rst_n = 1'b0;
        done_cnt = 0;
        step();
        check("rmid_out", {29'd0, pixel_valid, row_select != 2'b00, busy}, 32'd0);
        rst_n = 1'b1;
        pixel_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("rmid_no_done", done_cnt, 32'd0);
        xfers.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        run_to_idle("rmid");
        check_stream("rmid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
